// File: rtl/frogger_pkg.sv
// Shared Frogger game-state definitions: life-manager state encoding, frog spawn point
// and the default explosion length.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } life_state_t;

    localparam int FROG_INITIAL_X           = 320;
    localparam int FROG_INITIAL_Y           = 400;
    localparam int DEFAULT_EXPLOSION_CYCLES = 1000000;

    // A one-cycle explosion still needs a 1-bit counter.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/frog_life_manager_death_timer.sv
// Explosion timer: cleared by load, counts 0..LENGTH-1 while enabled, and raises done
// for the single cycle spent at the terminal count.
module death_timer
    import frogger_pkg::*;
#(
    parameter int LENGTH = DEFAULT_EXPLOSION_CYCLES,
    parameter int W      = timer_width(LENGTH)
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam logic [W-1:0] LAST = W'(LENGTH - 1);

    logic [W-1:0] count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || load) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + W'(1);
        end
    end

    assign done = enable && (count == LAST);

endmodule

// File: rtl/frog_life_manager.sv
// Frogger life/score controller: turns collision and goal flags into the death sequence,
// lives, saturating score, respawn pulses and the game-over banner.
module frog_life_manager
    import frogger_pkg::*;
#(
    parameter int EXPLOSION_CYCLES = DEFAULT_EXPLOSION_CYCLES,
    parameter int START_LIVES      = 3,
    parameter int LIVES_W          = 2,
    parameter int SCORE_W          = 8,
    parameter int POINTS_PER_GOAL  = 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Start,
    input  logic               i_Collision,
    input  logic               i_Goal,
    output logic               o_Freeze,
    output logic               o_Respawn,
    output logic               o_Explosion_Active,
    output logic [LIVES_W-1:0] o_Lives,
    output logic [SCORE_W-1:0] o_Score,
    output logic               o_Game_Over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W:0]   POINTS     = (SCORE_W + 1)'(POINTS_PER_GOAL);

    life_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_d;
    logic [SCORE_W-1:0] score_d;
    logic [SCORE_W:0]   score_sum;
    logic               respawn_d;
    logic               armed_q, armed_d;
    logic               goal_prev_q, start_prev_q;
    logic               goal_rise, start_rise;
    logic               death_load, death_enable, death_done;

    assign goal_rise    = i_Goal & ~goal_prev_q;
    assign start_rise   = i_Start & ~start_prev_q;
    assign score_sum    = {1'b0, o_Score} + POINTS;
    assign death_enable = (state_q == ST_DYING);

    death_timer #(
        .LENGTH(EXPLOSION_CYCLES)
    ) u_death_timer (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .load   (death_load),
        .enable (death_enable),
        .done   (death_done)
    );

    always_comb begin
        // NOTE: every target gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        lives_d    = o_Lives;
        score_d    = o_Score;
        respawn_d  = 1'b0;
        death_load = 1'b0;
        armed_d    = armed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_INIT;
                    score_d   = '0;
                    respawn_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (i_Collision && armed_q) begin
                    state_d    = ST_DYING;
                    death_load = 1'b1;
                    if (o_Lives != '0) lives_d = o_Lives - LIVES_W'(1);
                end else if (goal_rise) begin
                    score_d   = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                    respawn_d = 1'b1;
                end
            end
            ST_DYING: begin
                if (death_done) begin
                    if (o_Lives != '0) begin
                        state_d   = ST_PLAY;
                        respawn_d = 1'b1;
                    end else begin
                        state_d = ST_GAME_OVER;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_INIT;
                    score_d   = '0;
                    respawn_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The collision flag lags the frog by a cycle; after a respawn it must be seen low
        // in PLAY before another death is accepted.
        if (respawn_d) begin
            armed_d = 1'b0;
        end else if (state_q == ST_PLAY && !i_Collision) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q            <= ST_IDLE;
            o_Freeze           <= 1'b1;
            o_Respawn          <= 1'b0;
            o_Explosion_Active <= 1'b0;
            o_Lives            <= '0;
            o_Score            <= '0;
            o_Game_Over        <= 1'b0;
            armed_q            <= 1'b0;
            goal_prev_q        <= 1'b0;
            start_prev_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register here updates from pre-edge values.
            state_q            <= state_d;
            o_Freeze           <= (state_d != ST_PLAY);
            o_Respawn          <= respawn_d;
            o_Explosion_Active <= (state_d == ST_DYING);
            o_Lives            <= lives_d;
            o_Score            <= score_d;
            o_Game_Over        <= (state_d == ST_GAME_OVER);
            armed_q            <= armed_d;
            goal_prev_q        <= i_Goal;
            start_prev_q       <= i_Start;
        end
    end

endmodule

// File: tb/tb_frog_life_manager.sv
// Scenario bench for frog_life_manager with an 8-cycle explosion; a second instance with a
// 2-bit score shares the stimulus to exercise score saturation.
module tb_frog_life_manager;

    typedef struct packed {
        logic [1:0] lives;
        logic [7:0] score;
        logic       freeze;
        logic       expl;
        logic       go;
        logic       respawn;
    } snap_t;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Start = 1'b0;
    logic       i_Collision = 1'b0;
    logic       i_Goal = 1'b0;
    logic       o_Freeze, o_Respawn, o_Explosion_Active, o_Game_Over;
    logic [1:0] o_Lives;
    logic [7:0] o_Score;
    logic       freeze_s, respawn_s, expl_s, go_s;
    logic [1:0] lives_s, score_s;

    int    n_checks = 0;
    int    n_fail = 0;
    int    resp_total = 0;
    int    expl_total = 0;
    snap_t sb[$];

    always #5 i_Clk = ~i_Clk;

    frog_life_manager #(
        .EXPLOSION_CYCLES(8), .START_LIVES(3), .LIVES_W(2), .SCORE_W(8), .POINTS_PER_GOAL(1)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Collision(i_Collision),
        .i_Goal(i_Goal), .o_Freeze(o_Freeze), .o_Respawn(o_Respawn),
        .o_Explosion_Active(o_Explosion_Active), .o_Lives(o_Lives), .o_Score(o_Score),
        .o_Game_Over(o_Game_Over)
    );

    frog_life_manager #(
        .EXPLOSION_CYCLES(8), .START_LIVES(3), .LIVES_W(2), .SCORE_W(2), .POINTS_PER_GOAL(1)
    ) dut_small (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Collision(i_Collision),
        .i_Goal(i_Goal), .o_Freeze(freeze_s), .o_Respawn(respawn_s),
        .o_Explosion_Active(expl_s), .o_Lives(lives_s), .o_Score(score_s),
        .o_Game_Over(go_s)
    );

    always @(negedge i_Clk) begin
        if (o_Respawn === 1'b1) resp_total++;
        if (o_Explosion_Active === 1'b1) expl_total++;
    end

    function automatic snap_t snap();
        return '{lives: o_Lives, score: o_Score, freeze: o_Freeze, expl: o_Explosion_Active,
                 go: o_Game_Over, respawn: o_Respawn};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("lives=%0d score=%0d freeze=%b expl=%b game_over=%b respawn=%b",
                         s.lives, s.score, s.freeze, s.expl, s.go, s.respawn);
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        snap_t e, got;
        i_Reset = 1'b1;
        i_Start = 1'b1;
        sb.push_back('{lives: 2'd0, score: 8'd0, freeze: 1'b1, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(2);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %s expected %s", fmt(got), fmt(e));
        end
        i_Reset = 1'b0;
        i_Start = 1'b0;
        step(1);
    endtask

    task automatic test_start();
        snap_t e, got;
        int    base_r;
        base_r = resp_total;
        i_Start = 1'b1;
        sb.push_back('{lives: 2'd3, score: 8'd0, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b1});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL start_entry: got %s expected %s", fmt(got), fmt(e));
        end
        i_Start = 1'b0;
        sb.push_back('{lives: 2'd3, score: 8'd0, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL start_settle: got %s expected %s", fmt(got), fmt(e));
        end
        n_checks++;
        if (resp_total - base_r !== 1) begin
            n_fail++;
            $display("FAIL start_respawn_count: got %0d expected 1", resp_total - base_r);
        end
    endtask

    task automatic test_collision_held();
        snap_t e, got;
        int    base_r, base_e;
        step(1);
        base_r = resp_total;
        base_e = expl_total;
        i_Collision = 1'b1;
        sb.push_back('{lives: 2'd2, score: 8'd0, freeze: 1'b1, expl: 1'b1, go: 1'b0, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL death_entry: got %s expected %s", fmt(got), fmt(e));
        end
        step(19);
        i_Collision = 1'b0;
        sb.push_back('{lives: 2'd2, score: 8'd0, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL death_recover: got %s expected %s", fmt(got), fmt(e));
        end
        n_checks++;
        if (expl_total - base_e !== 8) begin
            n_fail++;
            $display("FAIL explosion_length: got %0d expected 8", expl_total - base_e);
        end
        n_checks++;
        if (resp_total - base_r !== 1) begin
            n_fail++;
            $display("FAIL death_respawn_count: got %0d expected 1", resp_total - base_r);
        end
    endtask

    task automatic test_goal();
        snap_t e, got;
        int    exp_score, exp_small;
        i_Goal = 1'b1;
        sb.push_back('{lives: 2'd2, score: 8'd1, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b1});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL goal_first: got %s expected %s", fmt(got), fmt(e));
        end
        step(4);
        i_Goal = 1'b0;
        sb.push_back('{lives: 2'd2, score: 8'd1, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL goal_held_once: got %s expected %s", fmt(got), fmt(e));
        end
        exp_score = 1;
        for (int k = 0; k < 4; k++) begin
            exp_score++;
            exp_small = (exp_score > 3) ? 3 : exp_score;
            i_Goal = 1'b1;
            sb.push_back('{lives: 2'd2, score: 8'(exp_score), freeze: 1'b0, expl: 1'b0, go: 1'b0,
                           respawn: 1'b1});
            step(1);
            i_Goal = 1'b0;
            e = sb.pop_front();
            got = snap();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL goal_pulse_%0d: got %s expected %s", k, fmt(got), fmt(e));
            end
            n_checks++;
            if (score_s !== 2'(exp_small)) begin
                n_fail++;
                $display("FAIL small_score_%0d: got %0d expected %0d", k, score_s, exp_small);
            end
            step(1);
        end
    endtask

    task automatic test_goal_and_collision();
        snap_t e, got;
        step(1);
        i_Goal = 1'b1;
        i_Collision = 1'b1;
        sb.push_back('{lives: 2'd1, score: 8'd5, freeze: 1'b1, expl: 1'b1, go: 1'b0, respawn: 1'b0});
        step(1);
        i_Goal = 1'b0;
        i_Collision = 1'b0;
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL simul_entry: got %s expected %s", fmt(got), fmt(e));
        end
        step(7);
        sb.push_back('{lives: 2'd1, score: 8'd5, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b1});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL simul_recover: got %s expected %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_game_over();
        snap_t e, got;
        int    base_r;
        step(1);
        i_Collision = 1'b1;
        sb.push_back('{lives: 2'd0, score: 8'd5, freeze: 1'b1, expl: 1'b1, go: 1'b0, respawn: 1'b0});
        step(1);
        i_Collision = 1'b0;
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL last_death: got %s expected %s", fmt(got), fmt(e));
        end
        base_r = resp_total;
        step(7);
        sb.push_back('{lives: 2'd0, score: 8'd5, freeze: 1'b1, expl: 1'b0, go: 1'b1, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL game_over_entry: got %s expected %s", fmt(got), fmt(e));
        end
        i_Goal = 1'b1;
        i_Collision = 1'b1;
        step(5);
        i_Goal = 1'b0;
        i_Collision = 1'b0;
        sb.push_back('{lives: 2'd0, score: 8'd5, freeze: 1'b1, expl: 1'b0, go: 1'b1, respawn: 1'b0});
        step(1);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL game_over_hold: got %s expected %s", fmt(got), fmt(e));
        end
        n_checks++;
        if (resp_total - base_r !== 0) begin
            n_fail++;
            $display("FAIL game_over_respawn_count: got %0d expected 0", resp_total - base_r);
        end
        i_Start = 1'b1;
        sb.push_back('{lives: 2'd3, score: 8'd0, freeze: 1'b0, expl: 1'b0, go: 1'b0, respawn: 1'b1});
        step(1);
        i_Start = 1'b0;
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL restart: got %s expected %s", fmt(got), fmt(e));
        end
        step(1);
    endtask

    task automatic test_reset_mid_dying();
        snap_t e, got;
        step(1);
        i_Collision = 1'b1;
        step(1);
        i_Collision = 1'b0;
        step(4);
        n_checks++;
        if (o_Explosion_Active !== 1'b1) begin
            n_fail++;
            $display("FAIL dying_before_reset: got expl=%b expected 1", o_Explosion_Active);
        end
        i_Reset = 1'b1;
        sb.push_back('{lives: 2'd0, score: 8'd0, freeze: 1'b1, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(1);
        i_Reset = 1'b0;
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_dying: got %s expected %s", fmt(got), fmt(e));
        end
        sb.push_back('{lives: 2'd0, score: 8'd0, freeze: 1'b1, expl: 1'b0, go: 1'b0, respawn: 1'b0});
        step(3);
        e = sb.pop_front();
        got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %s expected %s", fmt(got), fmt(e));
        end
        n_checks++;
        if (score_s !== 2'd0) begin
            n_fail++;
            $display("FAIL small_score_reset: got %0d expected 0", score_s);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_collision_held();
        test_goal();
        test_goal_and_collision();
        test_game_over();
        test_reset_mid_dying();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
